flash_addr_stepper: RTL and testbench
=====================================

# flash_addr_stepper

Button-driven read-address controller for the external flash path. It debounces the two board push-buttons and steps a 24-bit flash read address up or down. It also generates the `enableFlash` request window for `flashNavigator`, replacing the ad-hoc counter and `negedge btn1` logic in the top level. Its outputs connect directly to `flashNavigator`'s address and enable inputs; everything runs on the single system clock.

## Interface

Parameters:
- `ADDR_WIDTH`, 24: width of the flash read address.
- `ADDR_INIT`, 1: address loaded at reset.
- `ADDR_MAX`, 24'hFFFFFF: highest reachable address; stepping up is saturating.
- `DEBOUNCE_CYCLES`, 270000: consecutive stable cycles required to accept a level change (10 ms at 27 MHz).
- `ENABLE_CYCLES`, 10000000: length of the `enableFlash` window, in cycles.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn1`, in, 1: "step up" button; asynchronous, active-low (idle high).
- `btn2`, in, 1: "step down" button; asynchronous, active-low (idle high).
- `flashReadAddr`, out, `ADDR_WIDTH`: current read address, registered.
- `enableFlash`, out, 1: read-request window to `flashNavigator`, registered.
- `addrChanged`, out, 1: one-cycle pulse in the cycle `flashReadAddr` takes a new value.

## Operation

- **Input conditioning:** each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer holds a stable level that resets to 1.
  - A per-button counter increments while the synchronized value differs from the stable level, and clears to 0 whenever they match.
  - When the count reaches `DEBOUNCE_CYCLES`-1 while still differing, the stable level flips and the counter clears.
- **Press event:** one-cycle pulse when a stable level goes 1 to 0. Releases (0 to 1) generate nothing.
- **Event resolution**, in the cycle after the event:
  - up only: if `flashReadAddr` < `ADDR_MAX`, add 1; at `ADDR_MAX`, the address holds.
  - down only: if `flashReadAddr` > 0, subtract 1; at 0, the address holds.
  - up and down in the same cycle: both ignored; no change, no enable.
  - `addrChanged` pulses only when the value actually changes.
- **Enable FSM**, two states:
  - `ENABLE`: `enableFlash`=1 and the window counter runs. When the counter reaches `ENABLE_CYCLES`-1, go to `IDLE` and clear the counter.
  - `IDLE`: `enableFlash`=0. An accepted address change goes to `ENABLE` with the counter cleared.
  - An accepted change while in `ENABLE` restarts the counter at 0, extending the window.
  - A saturated or ignored press does not enter or restart `ENABLE`.
- **Reset** (in any state, mid-window or mid-debounce): `flashReadAddr`=`ADDR_INIT`, FSM=`ENABLE` with counter 0, `enableFlash`=1, `addrChanged`=0. Debounce counters clear to 0, stable levels and synchronizers go to 1, and pending events are dropped.
  - This gives one power-up read window, as today.

## Timing

- Reset values: `flashReadAddr`=`ADDR_INIT`, `enableFlash`=1, `addrChanged`=0.
- Press latency: `btn` falling, then held stable, updates `flashReadAddr` and `addrChanged` exactly 2 + `DEBOUNCE_CYCLES` + 1 rising edges after the first edge that samples the low level.
  - `enableFlash` rises, or its window restarts, on the same edge.
- Window length: `enableFlash` stays high for exactly `ENABLE_CYCLES` cycles after the last accepted change, or after reset release.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- Holding a button produces exactly one event; a new event requires a debounced release first.
- No combinational path from any input to any output.

## Structure

- Package `flash_ctrl_pkg` holds:
  - the `ADDR_WIDTH` default;
  - the FSM state encoding (`ST_IDLE`, `ST_ENABLE`);
  - the shared clock-rate constant used to derive `DEBOUNCE_CYCLES`.
- Sub-module `button_debounce` contains the synchronizer, debounce counter, stable level and falling-edge pulse. It is instantiated twice, for `btn1` and `btn2`.
- Top-level integration: the top instantiates `flash_addr_stepper` in place of its address/enable logic and feeds `flashNavigator` unchanged.

## Test plan

Run the bench with `DEBOUNCE_CYCLES`=4, `ENABLE_CYCLES`=8, `ADDR_MAX`=5.

- **Reset:** assert `rst` 2 cycles, release → `flashReadAddr`=1, `enableFlash`=1 for 8 cycles then 0, `addrChanged` never pulses.
- **Single press:** hold `btn1` low 20 cycles → address 2 exactly 7 edges after the first low sample, one `addrChanged` pulse, `enableFlash`=1 for 8 cycles.
- **Glitch and bounce:** drop `btn2` low for 3 cycles → no change. Then a bounce pattern 0,1,0,0,0,0,0,... on `btn1` → exactly one increment.
- **Saturation:** five `btn1` presses from 1 → address 5, fifth press gives no `addrChanged` and no window restart. From 0, a `btn2` press → address stays 0, `enableFlash` stays 0.
- **Simultaneous:** `btn1` and `btn2` fall in the same cycle → address unchanged, no enable. A press mid-window (counter at 5) → window restarts, `enableFlash` high for 8 more cycles.
- **Reset mid-operation:** `rst` during an active window and a half-counted debounce → address returns to 1, window restarts from 0, the pending press is not counted.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared constants and types for the flash read-address controller.
package flash_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF      = 24;
  localparam int unsigned CLK_HZ              = 27_000_000;
  localparam int unsigned DEBOUNCE_MS         = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned ENABLE_CYCLES_DEF   = 10_000_000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ENABLE = 1'b1
  } en_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_addr_stepper_if.sv
// Button inputs and flashNavigator-facing outputs of the address stepper.
interface flash_addr_stepper_if
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  btn1;
  logic                  btn2;
  logic [ADDR_WIDTH-1:0] flashReadAddr;
  logic                  enableFlash;
  logic                  addrChanged;

  // The stepper is the address master towards flashNavigator.
  modport master (
    input  btn1,
    input  btn2,
    output flashReadAddr,
    output enableFlash,
    output addrChanged
  );

  modport slave (
    output btn1,
    output btn2,
    input  flashReadAddr,
    input  enableFlash,
    input  addrChanged
  );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low push-button; pulses press_o once
// per accepted 1->0 transition of the stable level.
module button_debounce
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/flash_addr_stepper.sv
// Steps the flash read address from two debounced buttons and opens an
// enableFlash window after reset and after every accepted address change.
module flash_addr_stepper
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT       = ADDR_WIDTH'(1),
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX        = '1,
  parameter int unsigned           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned           ENABLE_CYCLES   = ENABLE_CYCLES_DEF
) (
  input logic                  clk,
  input logic                  rst,
  flash_addr_stepper_if.master bus
);

  localparam int unsigned   WW       = cnt_width(ENABLE_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(ENABLE_CYCLES - 1);

  logic                  up_evt, dn_evt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  changed_q, changed_d;
  en_state_e             state_q, state_d;
  logic [WW-1:0]         win_q, win_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.btn1),
    .press_o (up_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.btn2),
    .press_o (dn_evt)
  );

  // Simultaneous up/down cancel; saturated steps are not a change.
  always_comb begin
    addr_d    = addr_q;
    changed_d = 1'b0;
    if (up_evt && !dn_evt && (addr_q < ADDR_MAX)) begin
      addr_d    = addr_q + 1'b1;
      changed_d = 1'b1;
    end else if (dn_evt && !up_evt && (addr_q != '0)) begin
      addr_d    = addr_q - 1'b1;
      changed_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (changed_d) begin
          state_d = ST_ENABLE;
          win_d   = '0;
        end
      end
      ST_ENABLE: begin
        if (changed_d) begin
          win_d = '0;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= ADDR_INIT;
      changed_q <= 1'b0;
      state_q   <= ST_ENABLE;
      win_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      changed_q <= changed_d;
      state_q   <= state_d;
      win_q     <= win_d;
    end
  end

  assign bus.flashReadAddr = addr_q;
  assign bus.addrChanged   = changed_q;
  assign bus.enableFlash   = (state_q == ST_ENABLE);

endmodule

// File: tb/tb_flash_addr_stepper.sv
// Directed bench for flash_addr_stepper with DEBOUNCE_CYCLES=4, ENABLE_CYCLES=8, ADDR_MAX=5.
module tb_flash_addr_stepper;

  localparam int unsigned AW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass    = 0;
  int   n_total   = 0;
  int   n_pulses  = 0;
  int   p0        = 0;

  always #5 clk = ~clk;

  flash_addr_stepper_if #(.ADDR_WIDTH(AW)) bus ();

  flash_addr_stepper #(
    .ADDR_WIDTH      (AW),
    .ADDR_INIT       (24'd1),
    .ADDR_MAX        (24'd5),
    .DEBOUNCE_CYCLES (4),
    .ENABLE_CYCLES   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Counts addrChanged pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.addrChanged === 1'b1) n_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the selected buttons low and stop just after the 7th edge from the
  // first low sample, where an accepted press becomes visible.
  task automatic press(input logic b1, input logic b2);
    if (b1) bus.btn1 = 1'b0;
    if (b2) bus.btn2 = 1'b0;
    step(8);
  endtask

  task automatic release_all();
    bus.btn1 = 1'b1;
    bus.btn2 = 1'b1;
    step(12);
  endtask

  initial begin
    bus.btn1 = 1'b1;
    bus.btn2 = 1'b1;

    // Reset and the power-up window
    rst = 1'b1;
    step(2);
    check("rst_addr", 32'(bus.flashReadAddr), 32'd1);
    check("rst_en",   32'(bus.enableFlash),   32'd1);
    check("rst_chg",  32'(bus.addrChanged),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("pwrup_en_high", 32'(bus.enableFlash), 32'd1);
    end
    step(1);
    check("pwrup_en_low", 32'(bus.enableFlash), 32'd0);
    check("pwrup_no_pulse", 32'(n_pulses), 32'd0);
    check("pwrup_addr", 32'(bus.flashReadAddr), 32'd1);

    // Single press held 20 cycles
    bus.btn1 = 1'b0;
    step(7);
    check("single_e6_addr", 32'(bus.flashReadAddr), 32'd1);
    check("single_e6_en",   32'(bus.enableFlash),   32'd0);
    step(1);
    check("single_e7_addr", 32'(bus.flashReadAddr), 32'd2);
    check("single_e7_chg",  32'(bus.addrChanged),   32'd1);
    check("single_e7_en",   32'(bus.enableFlash),   32'd1);
    step(1);
    check("single_chg_drop", 32'(bus.addrChanged), 32'd0);
    step(6);
    check("single_win_last", 32'(bus.enableFlash), 32'd1);
    step(1);
    check("single_win_end", 32'(bus.enableFlash), 32'd0);
    step(4);
    release_all();
    check("single_one_pulse", 32'(n_pulses), 32'd1);
    check("single_hold_addr", 32'(bus.flashReadAddr), 32'd2);

    // Glitch on btn2 shorter than the debounce time
    p0 = n_pulses;
    bus.btn2 = 1'b0;
    step(3);
    bus.btn2 = 1'b1;
    step(12);
    check("glitch_addr",  32'(bus.flashReadAddr), 32'd2);
    check("glitch_pulse", 32'(n_pulses - p0),     32'd0);
    check("glitch_en",    32'(bus.enableFlash),   32'd0);

    // Bounce 0,1,0,0,... on btn1
    p0 = n_pulses;
    bus.btn1 = 1'b0;
    step(1);
    bus.btn1 = 1'b1;
    step(1);
    bus.btn1 = 1'b0;
    step(12);
    release_all();
    check("bounce_addr",  32'(bus.flashReadAddr), 32'd3);
    check("bounce_pulse", 32'(n_pulses - p0),     32'd1);

    // Saturation at ADDR_MAX
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(12);
    check("sat_start_addr", 32'(bus.flashReadAddr), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      press(1'b1, 1'b0);
      check("sat_up_addr", 32'(bus.flashReadAddr), 32'(i));
      check("sat_up_chg",  32'(bus.addrChanged),   32'd1);
      release_all();
    end
    p0 = n_pulses;
    press(1'b1, 1'b0);
    check("sat_max_addr", 32'(bus.flashReadAddr), 32'd5);
    check("sat_max_chg",  32'(bus.addrChanged),   32'd0);
    check("sat_max_en",   32'(bus.enableFlash),   32'd0);
    release_all();
    check("sat_max_pulse", 32'(n_pulses - p0), 32'd0);

    // Saturation at zero
    for (int i = 4; i >= 0; i--) begin
      press(1'b0, 1'b1);
      check("sat_dn_addr", 32'(bus.flashReadAddr), 32'(i));
      release_all();
    end
    p0 = n_pulses;
    press(1'b0, 1'b1);
    check("sat_zero_addr", 32'(bus.flashReadAddr), 32'd0);
    check("sat_zero_chg",  32'(bus.addrChanged),   32'd0);
    check("sat_zero_en",   32'(bus.enableFlash),   32'd0);
    release_all();
    check("sat_zero_pulse", 32'(n_pulses - p0), 32'd0);

    // Simultaneous up and down
    p0 = n_pulses;
    press(1'b1, 1'b1);
    check("simul_addr", 32'(bus.flashReadAddr), 32'd0);
    check("simul_en",   32'(bus.enableFlash),   32'd0);
    release_all();
    check("simul_pulse", 32'(n_pulses - p0), 32'd0);

    // Press landing mid-window (counter at 5) restarts the window
    bus.btn1 = 1'b0;
    step(6);
    bus.btn2 = 1'b0;
    step(2);
    check("midwin_up_addr", 32'(bus.flashReadAddr), 32'd1);
    check("midwin_up_chg",  32'(bus.addrChanged),   32'd1);
    step(5);
    check("midwin_cnt5_addr", 32'(bus.flashReadAddr), 32'd1);
    check("midwin_cnt5_en",   32'(bus.enableFlash),   32'd1);
    step(1);
    check("midwin_dn_addr", 32'(bus.flashReadAddr), 32'd0);
    check("midwin_dn_chg",  32'(bus.addrChanged),   32'd1);
    check("midwin_dn_en",   32'(bus.enableFlash),   32'd1);
    step(7);
    check("midwin_ext_high", 32'(bus.enableFlash), 32'd1);
    step(1);
    check("midwin_ext_end", 32'(bus.enableFlash), 32'd0);
    release_all();

    // Reset during an active window and a half-counted debounce
    press(1'b1, 1'b0);
    release_all();
    press(1'b1, 1'b0);
    check("rstmid_pre_addr", 32'(bus.flashReadAddr), 32'd2);
    check("rstmid_pre_en",   32'(bus.enableFlash),   32'd1);
    bus.btn1 = 1'b1;
    bus.btn2 = 1'b0;
    step(4);
    rst = 1'b1;
    bus.btn2 = 1'b1;
    step(2);
    check("rstmid_addr", 32'(bus.flashReadAddr), 32'd1);
    check("rstmid_en",   32'(bus.enableFlash),   32'd1);
    check("rstmid_chg",  32'(bus.addrChanged),   32'd0);
    rst = 1'b0;
    p0 = n_pulses;
    step(7);
    check("rstmid_win_high", 32'(bus.enableFlash), 32'd1);
    step(1);
    check("rstmid_win_end", 32'(bus.enableFlash), 32'd0);
    step(6);
    check("rstmid_final_addr", 32'(bus.flashReadAddr), 32'd1);
    check("rstmid_no_pulse",   32'(n_pulses - p0),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
